// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, defaults and geometry helpers for the byte-enabled RAM family
//
// Purpose: clear-FSM state encoding, default geometry and the lane-count
// helpers used by generic_dpram_be and generic_dpram_core.
// Ports: none (package).
package mem_pkg;

  typedef enum logic [0:0] {
    READY = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_DW = 32;
  localparam int DEF_BW = 8;
  localparam int nb     = DEF_DW / DEF_BW;

  function automatic int lanes(input int dw, input int bw);
    return dw / bw;
  endfunction

  // A word must split into whole byte lanes.
  function automatic bit geometry_ok(input int dw, input int bw);
    return (bw > 0) && (dw % bw == 0);
  endfunction

endpackage

// File: rtl/generic_dpram_be_if.sv
// rtl/generic_dpram_be_if.sv - write/read/clear bus bundle of the byte-enabled dual-port RAM
//
// Purpose: groups the memory bus so the user and the RAM share one handle.
// Ports (master view):
//   out clr, wr_en, wr_addr[aw], wr_be[nb], wr_data[dw], rd_en, rd_addr[aw]
//   in  init_busy, rd_q[dw], rd_valid
interface generic_dpram_be_if #(
  parameter int aw = 10,
  parameter int dw = 32,
  parameter int bw = 8
);
  localparam int nb = dw / bw;

  logic          clr;
  logic          init_busy;
  logic          wr_en;
  logic [aw-1:0] wr_addr;
  logic [nb-1:0] wr_be;
  logic [dw-1:0] wr_data;
  logic          rd_en;
  logic [aw-1:0] rd_addr;
  logic [dw-1:0] rd_q;
  logic          rd_valid;

  modport master (
    output clr, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  init_busy, rd_q, rd_valid
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output init_busy, rd_q, rd_valid
  );

endinterface

// File: rtl/generic_dpram_core.sv
// rtl/generic_dpram_core.sv - raw byte-enabled simple-dual-port array with registered read
//
// Purpose: storage only; no bypass, no clear. Same-address read and write on
// one edge return the old word.
// Ports:
//   clk                      clock, rising edge
//   we, waddr, wbe, wdata    write port, wbe[i] covers wdata[i*bw +: bw]
//   re, raddr                read strobe and address
//   q                        read data, updated on the edge after re
module generic_dpram_core
  import mem_pkg::*;
#(
  parameter int SIMULATION = 1,
  parameter int aw         = 10,
  parameter int dw         = 32,
  parameter int bw         = 8,
  parameter int wsize      = 1 << aw
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [dw/bw-1:0] wbe,
  input  logic [dw-1:0]    wdata,
  input  logic             re,
  input  logic [aw-1:0]    raddr,
  output logic [dw-1:0]    q
);
  localparam int nb_l = lanes(dw, bw);

  if (SIMULATION != 0) begin : g_beh
    logic [dw-1:0] mem [wsize];

    always_ff @(posedge clk) begin
      if (we) begin
        for (int i = 0; i < nb_l; i++) begin
          if (wbe[i]) mem[waddr][i*bw +: bw] <= wdata[i*bw +: bw];
        end
      end
      if (re) q <= mem[raddr];
    end
  end else begin : g_bram
    // One narrow array per lane: the shape block-RAM inference maps to
    // a byte-write-enable primitive.
    for (genvar l = 0; l < nb_l; l++) begin : g_lane
      logic [bw-1:0] lane_mem [wsize];
      logic [bw-1:0] lane_q;

      always_ff @(posedge clk) begin
        if (we && wbe[l]) lane_mem[waddr] <= wdata[l*bw +: bw];
        if (re) lane_q <= lane_mem[raddr];
      end

      assign q[l*bw +: bw] = lane_q;
    end
  end

endmodule

// File: rtl/generic_dpram_be.sv
// rtl/generic_dpram_be.sv - byte-enabled simple-dual-port RAM with clear sequencer and read-valid
//
// Purpose: wraps generic_dpram_core with a clear FSM, read-during-write
// merge, optional output register and a read-valid pipeline.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous reset, active high
//   bus   generic_dpram_be_if.slave: clr/init_busy, write port with byte
//         enables, read port with rd_q/rd_valid (latency 1 + OUT_REG)
module generic_dpram_be
  import mem_pkg::*;
#(
  parameter int SIMULATION = 1,
  parameter int aw         = 10,
  parameter int dw         = 32,
  parameter int bw         = 8,
  parameter int wsize      = 1 << aw,
  parameter int OUT_REG    = 0,
  parameter int NEW_DATA   = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic clk,
  input  logic rst,
  generic_dpram_be_if.slave bus
);
  localparam int            nb_l      = lanes(dw, bw);
  localparam clr_state_t    RST_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;
  localparam logic [aw-1:0] LAST      = aw'(wsize - 1);

  if (!geometry_ok(dw, bw)) begin : g_bad_geometry
    $error("generic_dpram_be: dw must be an integer multiple of bw");
  end

  // Clear sequencer
  clr_state_t    state, state_nxt;
  logic [aw-1:0] cnt, cnt_nxt;
  logic          ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      READY: begin
        if (bus.clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        // Counter parks on the last word instead of wrapping.
        if (cnt == LAST) state_nxt = READY;
        else             cnt_nxt   = cnt + 1'b1;
      end
    endcase
  end

  assign ready         = (state == READY);
  assign bus.init_busy = ~ready;

  // Core port mux: the sequencer owns the write port while clearing. The
  // write is held off during rst so reset never touches the array.
  logic             core_we, core_re;
  logic [aw-1:0]    core_waddr;
  logic [nb_l-1:0]  core_wbe;
  logic [dw-1:0]    core_wdata, core_q;

  assign core_we    = ready ? bus.wr_en : ~rst;
  assign core_waddr = ready ? bus.wr_addr : cnt;
  assign core_wbe   = ready ? bus.wr_be : '1;
  assign core_wdata = ready ? bus.wr_data : '0;
  assign core_re    = ready & bus.rd_en;

  generic_dpram_core #(
    .SIMULATION (SIMULATION),
    .aw         (aw),
    .dw         (dw),
    .bw         (bw),
    .wsize      (wsize)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .waddr (core_waddr),
    .wbe   (core_wbe),
    .wdata (core_wdata),
    .re    (core_re),
    .raddr (bus.rd_addr),
    .q     (core_q)
  );

  // The core returns the pre-write word on a collision; remember the
  // colliding write so its enabled lanes can be patched in a cycle later.
  logic             v1, byp_hit;
  logic [nb_l-1:0]  byp_be;
  logic [dw-1:0]    byp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      byp_hit  <= 1'b0;
      byp_be   <= '0;
      byp_data <= '0;
    end else begin
      v1      <= core_re;
      byp_hit <= (NEW_DATA != 0) && core_re && bus.wr_en
                 && (bus.wr_addr == bus.rd_addr);
      if (core_re) begin
        byp_be   <= bus.wr_be;
        byp_data <= bus.wr_data;
      end
    end
  end

  logic [dw-1:0] rd_word;

  always_comb begin
    rd_word = core_q;
    if (byp_hit) begin
      for (int i = 0; i < nb_l; i++) begin
        if (byp_be[i]) rd_word[i*bw +: bw] = byp_data[i*bw +: bw];
      end
    end
  end

  // Optional extra stage, then the output register that holds rd_q
  // between reads.
  logic          out_v;
  logic [dw-1:0] out_d;

  if (OUT_REG != 0) begin : g_out_reg
    logic          v2;
    logic [dw-1:0] q2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2 <= 1'b0;
        q2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) q2 <= rd_word;
      end
    end

    assign out_v = v2;
    assign out_d = q2;
  end else begin : g_no_out_reg
    assign out_v = v1;
    assign out_d = rd_word;
  end

  logic          rd_valid_r;
  logic [dw-1:0] rd_q_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_q_r     <= '0;
    end else begin
      rd_valid_r <= out_v;
      if (out_v) rd_q_r <= out_d;
    end
  end

  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_q     = rd_q_r;

endmodule

// File: tb/tb_generic_dpram_be.sv
// tb/tb_generic_dpram_be.sv - scoreboard bench for generic_dpram_be (two configurations side by side)
module tb_generic_dpram_be;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NB = 4;
  localparam int WS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          clr, wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [NB-1:0] wr_be;
  logic [DW-1:0] wr_data;

  generic_dpram_be_if #(.aw(AW), .dw(DW), .bw(BW)) bus_a ();
  generic_dpram_be_if #(.aw(AW), .dw(DW), .bw(BW)) bus_b ();

  assign bus_a.clr = clr;     assign bus_b.clr = clr;
  assign bus_a.wr_en = wr_en; assign bus_b.wr_en = wr_en;
  assign bus_a.wr_addr = wr_addr; assign bus_b.wr_addr = wr_addr;
  assign bus_a.wr_be = wr_be; assign bus_b.wr_be = wr_be;
  assign bus_a.wr_data = wr_data; assign bus_b.wr_data = wr_data;
  assign bus_a.rd_en = rd_en; assign bus_b.rd_en = rd_en;
  assign bus_a.rd_addr = rd_addr; assign bus_b.rd_addr = rd_addr;

  // A: latency 1, new data on collision, behavioural array.
  generic_dpram_be #(
    .SIMULATION(1), .aw(AW), .dw(DW), .bw(BW), .wsize(WS),
    .OUT_REG(0), .NEW_DATA(1), .INIT_CLEAR(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  // B: latency 2, old data on collision, per-lane array.
  generic_dpram_be #(
    .SIMULATION(0), .aw(AW), .dw(DW), .bw(BW), .wsize(WS),
    .OUT_REG(1), .NEW_DATA(0), .INIT_CLEAR(1)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit live = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: memory as an array of bytes.
  logic [7:0] mref [WS][NB];

  function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
    return {mref[a][3], mref[a][2], mref[a][1], mref[a][0]};
  endfunction

  task automatic ref_write(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [31:0] d);
    for (int i = 0; i < NB; i++)
      if (be[i]) mref[a][i] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  task automatic ref_clear();
    for (int a = 0; a < WS; a++)
      for (int i = 0; i < NB; i++) mref[a][i] = 8'h00;
  endtask

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents rd_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus_a.rd_valid) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_valid: rd_q %h with no read outstanding", bus_a.rd_q);
        end else begin
          e = qa.pop_front();
          check("a_rd_q", bus_a.rd_q, e.data);
          check("a_latency_cycle", cyc, e.due);
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
        e = qa.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL a_missing_valid: none at cycle %0d, required by cycle %0d", cyc, e.due);
      end
      if (bus_b.rd_valid) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_valid: rd_q %h with no read outstanding", bus_b.rd_q);
        end else begin
          e = qb.pop_front();
          check("b_rd_q", bus_b.rd_q, e.data);
          check("b_latency_cycle", cyc, e.due);
        end
      end else if (qb.size() != 0 && qb[0].due <= cyc) begin
        e = qb.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL b_missing_valid: none at cycle %0d, required by cycle %0d", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle; when the bench knows the RAM is READY the expected read
  // results are queued (A sees the post-write word, B the pre-write word).
  task automatic bus_cycle(input bit we, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                           input logic [31:0] wd, input bit re, input logic [AW-1:0] ra,
                           input bit c);
    exp_t e;
    logic [31:0] old_w, new_w;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra; clr = c;
    if (live) begin
      old_w = ref_word(ra);
      if (we) ref_write(wa, be, wd);
      new_w = ref_word(ra);
      if (re) begin
        e.data = new_w; e.due = cyc + 2; qa.push_back(e);
        e.data = old_w; e.due = cyc + 3; qb.push_back(e);
      end
    end
    step();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) step();
    if (qa.size() != 0 || qb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d/%0d reads still outstanding", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  // Counts busy cycles while hammering both ports with traffic that the
  // RAM must ignore.
  task automatic measure_busy(input string tag);
    int na = 0;
    int nbusy = 0;
    bit seen = 1'b0;
    rd_en = 1'b1; wr_en = 1'b1; wr_be = '1; wr_data = 32'hFFFF_FFFF;
    for (int k = 0; k < 64; k++) begin
      rd_addr = 4'($urandom_range(15));
      wr_addr = 4'($urandom_range(15));
      @(negedge clk);
      if (bus_a.init_busy) na++;
      if (bus_b.init_busy) nbusy++;
      if (k >= 3 && (bus_a.rd_valid || bus_b.rd_valid)) seen = 1'b1;
      if (!bus_a.init_busy && !bus_b.init_busy) break;
    end
    rd_en = 1'b0; wr_en = 1'b0;
    check({tag, "_busy_cycles_a"}, na, 16);
    check({tag, "_busy_cycles_b"}, nbusy, 16);
    check({tag, "_no_valid_while_busy"}, {31'd0, seen}, 32'd0);
    step();
  endtask

  task automatic read_all();
    for (int a = 0; a < WS; a++) bus_cycle(1'b0, '0, '0, '0, 1'b1, 4'(a), 1'b0);
    drain();
  endtask

  task automatic write_all_nonzero();
    for (int a = 0; a < WS; a++) bus_cycle(1'b1, 4'(a), 4'hF, $urandom | 32'h0100_0000, 1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_rd_valid"}, {31'd0, bus_a.rd_valid}, 32'd0);
    check({tag, "_a_rd_q"}, bus_a.rd_q, 32'd0);
    check({tag, "_a_init_busy"}, {31'd0, bus_a.init_busy}, 32'd1);
    check({tag, "_b_rd_valid"}, {31'd0, bus_b.rd_valid}, 32'd0);
    check({tag, "_b_rd_q"}, bus_b.rd_q, 32'd0);
    check({tag, "_b_init_busy"}, {31'd0, bus_b.init_busy}, 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] peek;
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;

    // Nonzero garbage that the power-on clear has to wipe.
    for (int i = 0; i < WS; i++) begin
      v = $urandom | 32'h0000_0101;
      dut_a.u_core.g_beh.mem[i] = v;
      dut_b.u_core.g_bram.g_lane[0].lane_mem[i] = v[7:0];
      dut_b.u_core.g_bram.g_lane[1].lane_mem[i] = v[15:8];
      dut_b.u_core.g_bram.g_lane[2].lane_mem[i] = v[23:16];
      dut_b.u_core.g_bram.g_lane[3].lane_mem[i] = v[31:24];
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    @(posedge clk); #1;
    rst = 1'b0;
    measure_busy("init_clear");
    ref_clear();
    live = 1'b1;
    read_all();

    // Byte enables: lanes 0 and 2 of the second write land.
    bus_cycle(1'b1, 4'd3, 4'b1111, 32'hAABB_CCDD, 1'b0, '0, 1'b0);
    bus_cycle(1'b1, 4'd3, 4'b0101, 32'h1122_3344, 1'b0, '0, 1'b0);
    bus_cycle(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
    drain();

    // Back-to-back reads stream at one word per cycle.
    for (int a = 0; a < 4; a++) bus_cycle(1'b1, 4'(a), 4'hF, 32'h10 + a, 1'b0, '0, 1'b0);
    for (int a = 0; a < 4; a++) bus_cycle(1'b0, '0, '0, '0, 1'b1, 4'(a), 1'b0);
    drain();
    repeat (3) step();
    check("rd_q_hold_a", bus_a.rd_q, 32'h13);
    check("rd_q_hold_b", bus_b.rd_q, 32'h13);

    // Read-during-write on the same address.
    bus_cycle(1'b1, 4'd5, 4'hF, 32'h0102_0304, 1'b0, '0, 1'b0);
    bus_cycle(1'b1, 4'd5, 4'b0011, 32'hFFFF_FFFF, 1'b1, 4'd5, 1'b0);
    bus_cycle(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
    drain();

    // Random traffic with frequent collisions.
    for (int k = 0; k < 200; k++) begin
      logic [AW-1:0] wa, ra;
      wa = 4'($urandom_range(15));
      ra = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
      bus_cycle(1'($urandom_range(1)), wa, 4'($urandom_range(15)), $urandom,
                1'($urandom_range(1)), ra, 1'b0);
    end
    drain();

    // Runtime clear: the write and read sharing the clr cycle still happen.
    write_all_nonzero();
    bus_cycle(1'b1, 4'd2, 4'hF, 32'hCAFE_0002, 1'b1, 4'd2, 1'b1);
    peek = dut_a.u_core.g_beh.mem[2];
    check("clr_cycle_write_a", peek, 32'hCAFE_0002);
    peek = {dut_b.u_core.g_bram.g_lane[3].lane_mem[2], dut_b.u_core.g_bram.g_lane[2].lane_mem[2],
            dut_b.u_core.g_bram.g_lane[1].lane_mem[2], dut_b.u_core.g_bram.g_lane[0].lane_mem[2]};
    check("clr_cycle_write_b", peek, 32'hCAFE_0002);
    live = 1'b0;
    measure_busy("runtime_clear");
    drain();
    ref_clear();
    live = 1'b1;
    read_all();

    // Reset at clear cycle 7 restarts the full clear.
    write_all_nonzero();
    bus_cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    live = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check_reset_outputs("mid_clear_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    measure_busy("restarted_clear");
    ref_clear();
    live = 1'b1;
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/generic_dpram_be.md
Name: generic_dpram_be

Overview:
Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one read port, both on one clock. It is the next generation of our single-port memory wrapper. It adds:
- selectable read latency (1 or 2 cycles)
- a defined read-during-write mode
- a read-valid strobe
- a built-in clear sequencer that zeroes the array after reset or on request

It backs buffers in the ultrasound data path, for example line buffers, sample FIFOs and coefficient tables.

Parameters:
SIMULATION, 1, 1 = behavioural array; 0 = vendor block RAM plus wrapper logic. Both must behave identically at the ports.
aw, 10, address bits.
dw, 32, data bits; must be an integer multiple of bw.
bw, 8, bits per byte lane. nb = dw/bw lanes.
wsize, 1<<aw, number of words.
OUT_REG, 0, 1 = extra output register (read latency 2); 0 = latency 1.
NEW_DATA, 1, same-address read/write in the same cycle: 1 = read returns the new (merged) data; 0 = read returns the old data.
INIT_CLEAR, 1, 1 = zero the whole array after reset deassertion.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active high.
clr  in  1  single-cycle pulse that starts a full clear; honoured only in READY.
init_busy  out  1  high while a clear is pending or in progress.
wr_en  in  1  write strobe.
wr_addr  in  aw  write address.
wr_be  in  nb  byte-lane enables; bit i covers data[i*bw +: bw].
wr_data  in  dw  write data.
rd_en  in  1  read strobe.
rd_addr  in  aw  read address.
rd_q  out  dw  read data.
rd_valid  out  1  high for one cycle when rd_q carries the result of a read.

Behaviour:
Reset values (asynchronous, while rst=1):
- rd_q=0, rd_valid=0, pipeline valid flags=0.
- init_busy=INIT_CLEAR.
- FSM in CLEAR if INIT_CLEAR=1, else READY.
- Clear counter=0.
- The array contents are not reset.

Clear FSM states:
- READY: normal operation. A clr pulse moves to CLEAR, counter=0, and init_busy rises on the next cycle.
- CLEAR: writes all-zeros to address = counter, one word per cycle. The counter increments each cycle. At counter=wsize-1, after writing that word, the FSM goes to READY and init_busy drops the same edge. The clear takes exactly wsize cycles after rst deassertion or after clr.

During CLEAR:
- wr_en and rd_en are ignored: no write, rd_valid stays 0.
- clr is ignored.

Reset during CLEAR aborts it. The full clear restarts from address 0 after deassertion.

Write (READY only):
- On a clk edge with wr_en=1, each lane with wr_be[i]=1 is updated.
- Lanes with wr_be[i]=0 keep their value.
- wr_be=0 with wr_en=1 is a legal no-op.

Read (READY only):
- rd_en=1 at edge N gives rd_q and rd_valid=1 after edge N+1+OUT_REG.
- Back-to-back reads stream at one word per cycle.
- rd_q holds its last value when rd_valid=0; it is not zeroed.
- A read issued in the last READY cycle before a clr completes normally.

Read-during-write, same address and same edge:
- NEW_DATA=1: lanes with wr_be set come from wr_data; the other lanes come from the old memory contents.
- NEW_DATA=0: rd_q is the pre-write word.

Different addresses never interact.

The address counter is aw bits wide and stops at wsize-1; it does not wrap.

Decomposition:
Shared package mem_pkg holds:
- clear-FSM state encoding (READY, CLEAR)
- localparam nb = dw/bw
- the elaboration-time check that dw % bw == 0

Natural sub-module: generic_dpram_core. It holds the raw byte-enabled array only: the write port with lanes and a registered read, with no bypass and no clear. It has the behavioural/vendor generate split keyed on SIMULATION. generic_dpram_be wraps it with:
- the clear FSM
- the clear-write mux onto the core write port
- bypass/merge logic
- the OUT_REG stage
- the valid pipeline

Test Plan:
- Clear after reset (aw=4, dw=32, bw=8, INIT_CLEAR=1): preload the array via the behavioural model, then release rst. Required: init_busy high for exactly 16 cycles; reads of addresses 0..15 afterwards return 0x00000000; rd_en during busy yields no rd_valid.
- Byte enables: write 0xAABBCCDD to addr 3 with be=1111, then 0x11223344 with be=0101. Required: a read of addr 3 returns 0xAA22CC44.
- Latency: OUT_REG=0, then 1. Issue rd_en on 4 consecutive cycles for addrs 0..3 holding 0x10..0x13. Required: rd_valid high for 4 cycles starting at 1 (respectively 2) edges after the first rd_en, with data in order.
- Read-during-write: addr 5 holds 0x01020304. Same cycle: write 0xFFFFFFFF with be=0011, read addr 5. Required: NEW_DATA=1 returns 0x0102FFFF; NEW_DATA=0 returns 0x01020304. A following read returns 0x0102FFFF in both modes.
- Reset mid-clear: assert rst at clear cycle 7, then release. Required: init_busy stays high and the clear restarts at 0, lasting a full 16 cycles; all words read 0 afterwards.
- Runtime clr: in READY, write nonzero data to all addrs, then pulse clr together with wr_en to addr 2. Required: the addr-2 write is performed; init_busy is high for 16 cycles starting the next cycle; every address then reads 0.
